// File: rtl/mem_access_seq_if.sv
// Bundle between the control FSM, the access sequencer and the memory port.
// master = sequencer view, slave = control/memory side view.
interface mem_access_seq_if #(
  parameter int DATA_W = 32
) ();
  localparam int NBYTES = DATA_W / 8;

  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clr_err;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [1:0]        err_code;

  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NBYTES-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  start, is_store, funct3, addr, wdata, clr_err, mem_rdata, mem_resp,
    output busy, done, rdata, err, err_code,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output start, is_store, funct3, addr, wdata, clr_err, mem_rdata, mem_resp,
    input  busy, done, rdata, err, err_code,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_access_seq.sv
// Multi-cycle load/store sequencer: width/alignment checks, lane shifting,
// load extension, response timeout with bounded re-issue, sticky error state.
module mem_access_seq #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mem_access_seq_if.master bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  state_t            r_state, w_next;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [NBYTES-1:0] r_mem_be;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err_code;
  logic [TW-1:0]     r_tmo;
  logic [RW-1:0]     r_retry;

  logic              w_illegal, w_misal, w_tmo_hit, w_can_retry;
  logic [OFFW-1:0]   w_off;
  logic [NBYTES-1:0] w_be_base, w_be;
  logic [DATA_W-1:0] w_st_wdata, w_sh, w_ext;

  // Start-time checks operate on the live inputs, which are only meaningful in IDLE.
  always_comb begin
    w_illegal = 1'b0;
    if (bus.is_store)
      w_illegal = bus.funct3[2] || (DATA_W == 32 && bus.funct3[1:0] == 2'b11);
    else
      w_illegal = (bus.funct3 == 3'b111) || (DATA_W == 32 && bus.funct3 == 3'b011);
  end

  always_comb begin
    case (bus.funct3[1:0])
      2'd1:    w_misal = bus.addr[0];
      2'd2:    w_misal = |bus.addr[1:0];
      2'd3:    w_misal = |bus.addr[2:0];
      default: w_misal = 1'b0;
    endcase
  end

  assign w_off = bus.addr[OFFW-1:0];

  always_comb begin
    case (bus.funct3[1:0])
      2'd0:    w_be_base = NBYTES'(1);
      2'd1:    w_be_base = NBYTES'(3);
      2'd2:    w_be_base = NBYTES'(15);
      default: w_be_base = '1;
    endcase
  end

  assign w_be       = bus.is_store ? (w_be_base << w_off) : '1;
  assign w_st_wdata = bus.wdata << {w_off, 3'b000};

  // Load extension uses the latched width/sign and lane offset.
  assign w_sh = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_funct3[1:0])
      2'd0: w_ext = r_funct3[2] ? DATA_W'(w_sh[7:0])  : DATA_W'($signed(w_sh[7:0]));
      2'd1: w_ext = r_funct3[2] ? DATA_W'(w_sh[15:0]) : DATA_W'($signed(w_sh[15:0]));
      2'd2: w_ext = r_funct3[2] ? DATA_W'(w_sh[31:0]) : DATA_W'($signed(w_sh[31:0]));
      default: w_ext = w_sh;
    endcase
  end

  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_can_retry = (r_retry < RW'(MAX_RETRY));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (bus.start) begin
          if (w_illegal || w_misal) w_next = S_ERR;
          else                      w_next = S_ISSUE;
        end
      S_ISSUE: w_next = S_WAIT;
      // A response arriving on the timeout cycle still completes the access.
      S_WAIT:
        if (bus.mem_resp)   w_next = r_is_store ? S_DONE : S_CAPTURE;
        else if (w_tmo_hit) w_next = w_can_retry ? S_ISSUE : S_ERR;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      S_ERR:     if (bus.clr_err) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rdata     <= '0;
      r_err_code  <= '0;
      r_tmo       <= '0;
      r_retry     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:
          if (bus.start) begin
            r_is_store <= bus.is_store;
            r_funct3   <= bus.funct3;
            r_off      <= w_off;
            r_retry    <= '0;
            if (w_illegal)    r_err_code <= 2'd2;
            else if (w_misal) r_err_code <= 2'd1;
            else begin
              r_mem_addr  <= {bus.addr[DATA_W-1:OFFW], {OFFW{1'b0}}};
              r_mem_be    <= w_be;
              r_mem_wdata <= bus.is_store ? w_st_wdata : '0;
            end
          end
        S_ISSUE: r_tmo <= '0;
        S_WAIT:
          if (!bus.mem_resp) begin
            if (w_tmo_hit) begin
              r_tmo <= '0;
              if (w_can_retry) r_retry    <= r_retry + 1'b1;
              else             r_err_code <= 2'd3;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        S_CAPTURE: r_rdata <= w_ext;
        S_DONE:    r_retry <= '0;
        S_ERR:     if (bus.clr_err) r_err_code <= 2'd0;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                         (r_state == S_CAPTURE) || (r_state == S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_ERR);
  assign bus.err_code  = r_err_code;
  assign bus.rdata     = r_rdata;
  assign bus.mem_read  = (r_state == S_ISSUE) && !r_is_store;
  assign bus.mem_write = (r_state == S_ISSUE) &&  r_is_store;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_mem_access_seq.sv
// Randomised bench for mem_access_seq: 32- and 64-bit instances driven from
// shared stimulus, checked against an arithmetic reference of the access rules.
module tb_mem_access_seq;
  localparam int T  = 4;
  localparam int MR = 2;

  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic        start = 1'b0, is_store = 1'b0, clr_err = 1'b0, mem_resp = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0, wdata = '0, mem_rdata = '0;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] held [2];

  logic        o_busy, o_done, o_err, o_rd, o_wr;
  logic [1:0]  o_code;
  logic [7:0]  o_be;
  logic [63:0] o_rdata, o_maddr, o_mwdata;

  mem_access_seq_if #(.DATA_W(32)) b32 ();
  mem_access_seq_if #(.DATA_W(64)) b64 ();

  assign b32.start     = start & ~sel;
  assign b32.is_store  = is_store;
  assign b32.funct3    = funct3;
  assign b32.addr      = addr[31:0];
  assign b32.wdata     = wdata[31:0];
  assign b32.clr_err   = clr_err & ~sel;
  assign b32.mem_rdata = mem_rdata[31:0];
  assign b32.mem_resp  = mem_resp & ~sel;
  assign b64.start     = start & sel;
  assign b64.is_store  = is_store;
  assign b64.funct3    = funct3;
  assign b64.addr      = addr;
  assign b64.wdata     = wdata;
  assign b64.clr_err   = clr_err & sel;
  assign b64.mem_rdata = mem_rdata;
  assign b64.mem_resp  = mem_resp & sel;

  mem_access_seq #(.DATA_W(32), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) u32 (
    .i_clk(clk), .i_rst(rst), .bus(b32));
  mem_access_seq #(.DATA_W(64), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) u64 (
    .i_clk(clk), .i_rst(rst), .bus(b64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    if (sel) begin
      o_busy = b64.busy; o_done = b64.done; o_err = b64.err; o_code = b64.err_code;
      o_rd = b64.mem_read; o_wr = b64.mem_write; o_be = b64.mem_be;
      o_rdata = b64.rdata; o_maddr = b64.mem_addr; o_mwdata = b64.mem_wdata;
    end else begin
      o_busy = b32.busy; o_done = b32.done; o_err = b32.err; o_code = b32.err_code;
      o_rd = b32.mem_read; o_wr = b32.mem_write; o_be = {4'b0, b32.mem_be};
      o_rdata = {32'b0, b32.rdata}; o_maddr = {32'b0, b32.mem_addr};
      o_mwdata = {32'b0, b32.mem_wdata};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- reference model: plain arithmetic on the access rules ----
  function automatic logic [63:0] wmask(int nb);
    return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int m_code(bit st, logic [2:0] f, logic [63:0] a, int nb);
    bit ill;
    int sz;
    if (st) ill = f[2] || (f[1:0] == 2'b11 && nb == 4);
    else    ill = (f == 3'b111) || (f == 3'b011 && nb == 4);
    if (ill) return 2;
    sz = 1 << f[1:0];
    if ((a % 64'(sz)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] m_be(bit st, logic [2:0] f, logic [63:0] a, int nb);
    int sz, off;
    sz  = 1 << f[1:0];
    off = int'(a % 64'(nb));
    if (!st) return (64'd1 << nb) - 64'd1;
    return ((64'd1 << sz) - 64'd1) << off;
  endfunction

  function automatic logic [63:0] m_rdata(logic [2:0] f, logic [63:0] a, logic [63:0] rd, int nb);
    int off, bits;
    logic [63:0] v, m;
    off  = int'(a % 64'(nb));
    bits = 8 * (1 << f[1:0]);
    v = (rd & wmask(nb)) >> (8 * off);
    m = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v = v & m;
    if (!f[2] && v[bits-1]) v = v | ~m;
    return v & wmask(nb);
  endfunction

  // One access; r_iss = issue index that gets the response (-1 = never),
  // r_w = WAIT cycle of that response, noisy = stale resps and start during busy.
  task automatic access(input bit s64, input bit st, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int r_iss, input int r_w, input bit noisy);
    int nb, code, t0, issues, last_iss, lat;
    bit fin;
    nb = s64 ? 8 : 4;
    a = a & wmask(nb); wd = wd & wmask(nb); rd = rd & wmask(nb);
    code = m_code(st, f, a, nb);
    @(negedge clk);
    sel = s64; start = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd; t0 = cyc;
    @(negedge clk);
    start = 1'b0; is_store = ~st; funct3 = 3'($urandom);
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (code != 0) begin
      chk("err_set", o_err, 1'b1);
      chk("err_code", o_code, code);
      chk("err_not_busy", o_busy, 1'b0);
      chk("err_no_req", o_rd | o_wr, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_sticky", o_err, 1'b1);
      chk("err_code_held", o_code, code);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err", o_err, 1'b0);
      chk("clr_code", o_code, 2'd0);
      return;
    end
    issues = 0; last_iss = 0; fin = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      mem_resp = 1'b0; start = 1'b0;
      if (o_rd || o_wr) begin
        if (issues == 0) chk("first_issue_at", cyc - t0, 1);
        chk("req_kind", {o_rd, o_wr}, st ? 2'b01 : 2'b10);
        chk("mem_addr", o_maddr, a - (a % 64'(nb)));
        chk("mem_be", o_be, m_be(st, f, a, nb));
        if (st) chk("mem_wdata", o_mwdata, (wd << (8 * int'(a % 64'(nb)))) & wmask(nb));
        issues++; last_iss = cyc;
        if (noisy) begin mem_resp = 1'b1; mem_rdata = {$urandom, $urandom}; end
      end else if (o_done) begin
        fin = 1'b1;
        lat = 1 + r_iss * (T + 1) + 1 + r_w + (st ? 1 : 2);
        chk("done_latency", cyc - t0, lat);
        chk("issue_count", issues, r_iss + 1);
        chk("done_addr_held", o_maddr, a - (a % 64'(nb)));
        if (!st) held[s64] = m_rdata(f, a, rd, nb);
        chk("rdata", o_rdata, held[s64]);
      end else if (o_err) begin
        fin = 1'b1;
        chk("tmo_expected", r_iss, -1);
        chk("tmo_code", o_code, 2'd3);
        chk("tmo_at", cyc - t0, 1 + (MR + 1) * (T + 1));
        chk("tmo_issues", issues, MR + 1);
      end else begin
        chk("busy", o_busy, 1'b1);
        if (issues - 1 == r_iss && cyc - last_iss == r_w + 1) begin
          mem_resp = 1'b1; mem_rdata = rd;
        end else if (noisy) begin
          start = 1'($urandom);
        end
      end
      if (!fin) @(negedge clk);
    end
    chk("access_bound", fin, 1'b1);
    mem_resp = 1'b0; start = 1'b0;
    if (o_err) begin
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("tmo_clr", o_err, 1'b0);
    end else begin
      @(negedge clk);
      chk("done_pulse", o_done, 1'b0);
      chk("idle_busy", o_busy, 1'b0);
      chk("rdata_hold", o_rdata, held[s64]);
    end
  endtask

  task automatic check_zero(input bit s64, input string tag);
    sel = s64;
    #1;
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_err"}, {o_err, o_code}, 3'b0);
    chk({tag, "_req"}, {o_rd, o_wr}, 2'b0);
    chk({tag, "_rdata"}, o_rdata, 64'd0);
    chk({tag, "_maddr"}, o_maddr, 64'd0);
    chk({tag, "_mwdata"}, o_mwdata, 64'd0);
    chk({tag, "_be"}, o_be, 8'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit st, s64, noisy;
    logic [2:0] f;
    logic [63:0] a;
    int ri, rw;
    held[0] = '0; held[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero(1'b0, "rst32");
    check_zero(1'b1, "rst64");

    access(0, 0, 3'b000, 64'h103, 0, 64'h80FF_FF11, 0, 0, 0);
    chk("lb_literal", o_rdata, 64'hFFFF_FF80);
    access(0, 1, 3'b001, 64'h202, 64'h0000_BEEF, 0, 0, 0, 0);
    access(0, 0, 3'b010, 64'h006, 0, 0, 0, 0, 0);
    access(0, 0, 3'b010, 64'h040, 0, 64'h1111_2222, -1, 0, 0);
    access(0, 0, 3'b010, 64'h040, 0, 64'h1234_5678, 1, 0, 1);
    chk("retry_literal", o_rdata, 64'h1234_5678);
    access(0, 0, 3'b011, 64'h008, 0, 0, 0, 0, 0);
    access(1, 0, 3'b011, 64'h008, 0, 64'h8877_6655_4433_2211, 0, 0, 0);
    chk("ld64_literal", o_rdata, 64'h8877_6655_4433_2211);
    access(1, 1, 3'b011, 64'h010, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, T - 1, 0);

    // Reset in WAIT abandons the access; a following response must be ignored.
    @(negedge clk);
    sel = 1'b0; start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 64'h10;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; mem_resp = 1'b1; mem_rdata = 64'hFFFF_FFFF;
    @(negedge clk); mem_resp = 1'b0;
    held[0] = '0; held[1] = '0;
    check_zero(1'b0, "rstwait32");
    @(negedge clk);
    check_zero(1'b0, "rstwait32b");
    check_zero(1'b1, "rstwait64");

    access(0, 0, 3'b101, 64'h002, 0, 64'hFFFF_0000, 0, 2, 1);
    chk("lhu_literal", o_rdata, 64'h0000_FFFF);

    for (int n = 0; n < 300; n++) begin
      s64 = 1'($urandom); st = 1'($urandom); f = 3'($urandom);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) a[2:0] = 3'b000;
      ri = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, MR));
      rw = int'($urandom_range(0, T - 1));
      noisy = 1'($urandom);
      access(s64, st, f, a, {$urandom, $urandom}, {$urandom, $urandom}, ri, rw, noisy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Parametrised multi-cycle memory access sequencer for the RV32I/RV64I control path. It replaces the fixed word-only load/store state sequences with one engine. The engine supports byte, halfword, word and (when DATA_W=64) doubleword accesses, lane-shifted write data with byte enables, sign/zero extension on loads, a response timeout with bounded re-issue, and sticky error reporting. The control FSM pulses start and waits for done or err; the sequencer owns the memory port during the access.

Parameters:
DATA_W, 32, memory/register width; legal values 32 or 64; NBYTES=DATA_W/8
TIMEOUT_CYCLES, 64, WAIT cycles without mem_resp before a timeout is declared; must be >=2
MAX_RETRY, 2, re-issues allowed after timeout before error; 0 disables retry

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin access; sampled only in IDLE
is_store  in  1  1=store, 0=load; sampled with start
funct3  in  3  RISC-V width/sign field; sampled with start
addr  in  DATA_W  effective byte address; sampled with start
wdata  in  DATA_W  store data, low bits significant; sampled with start
clr_err  in  1  clears ERR state
busy  out  1  high in ISSUE, WAIT, CAPTURE, DONE
done  out  1  one-cycle pulse, access complete
rdata  out  DATA_W  extended load result; valid when done, held until next start
err  out  1  high while in ERR
err_code  out  2  0=none, 1=misaligned, 2=illegal funct3, 3=timeout
mem_read  out  1  one-cycle read request pulse
mem_write  out  1  one-cycle write request pulse
mem_addr  out  DATA_W  addr with low log2(NBYTES) bits cleared
mem_wdata  out  DATA_W  lane-shifted store data
mem_be  out  NBYTES  byte enables; all ones for reads
mem_rdata  in  DATA_W  read data, valid with mem_resp
mem_resp  in  1  memory response

Behaviour:
- Reset: state=IDLE. All outputs are 0: busy, done, rdata, err, err_code, mem_read, mem_write, mem_addr, mem_wdata, mem_be. Retry and timeout counters are 0. Reset mid-access abandons the access; a later mem_resp is ignored.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE, ERR.
- IDLE, start=1: latch is_store, funct3, addr, wdata. Checks are evaluated in this priority:
  - Illegal funct3 -> ERR, code 2. Illegal loads are 011 when DATA_W=32, and 111. Illegal stores are funct3[2]=1, and 011 when DATA_W=32.
  - Misaligned -> ERR, code 1. Halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0.
  - Otherwise -> ISSUE.
- start outside IDLE is ignored.
- ISSUE, one cycle: assert mem_read or mem_write and drive mem_addr, mem_be, mem_wdata. Clear the timeout counter, then go to WAIT. mem_addr, mem_be and mem_wdata are held constant from ISSUE through DONE.
- Byte lane offset off = addr[log2(NBYTES)-1:0].
  - Store: mem_be = (byte ? 1 : half ? 3 : word ? 'hF : all ones) << off; mem_wdata = wdata << 8*off.
  - Load: mem_be = all ones.
- WAIT: mem_resp=1 -> CAPTURE for loads, DONE for stores. Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no resp: if retry < MAX_RETRY, retry++ and go to ISSUE. Else go to ERR with code 3.
  - mem_resp in the same cycle as the timeout wins; no timeout is declared.
- CAPTURE: rdata <= extend(mem_rdata >> 8*off).
  - funct3[2]=0: sign-extend from bit 7, 15 or 31 (byte/half/word); doubleword is unextended.
  - funct3[2]=1: zero-extend.
  - Next state is DONE.
- DONE: done=1 for one cycle, clear retry, go to IDLE.
- mem_resp outside WAIT is ignored, including stale responses during ISSUE of a retry.
- ERR: err=1, err_code held, busy=0. Stays in ERR until clr_err=1; clr_err clears err_code and goes to IDLE next cycle. start in ERR is ignored.
- Latency (start at cycle 0, resp in first WAIT cycle 2): load done at cycle 4; store done at cycle 3. Each extra WAIT cycle adds 1.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_FF11, resp in first WAIT -> mem_addr=0x100, mem_read pulse at cycle 1, rdata=0xFFFF_FF80, done at cycle 4.
- SH at addr 0x202, wdata=0x0000_BEEF -> mem_write pulse, mem_be=4'b1100, mem_wdata=0xBEEF_0000, mem_addr=0x200, done at cycle 3.
- LW at addr 0x006 -> err=1, err_code=1 one cycle after start, no mem_read. clr_err -> IDLE, err=0, err_code=0.
- LW with no mem_resp, TIMEOUT_CYCLES=4, MAX_RETRY=2 -> 3 mem_read pulses, then err_code=3. Repeat with resp on the 2nd issue -> done, no err.
- Load funct3=011 with DATA_W=32 -> err_code=2. Same stimulus with DATA_W=64, addr 0x8 -> mem_be=8'hFF, rdata=mem_rdata.
- rst asserted in WAIT, then mem_resp pulse -> IDLE, no done, all outputs 0. start during busy ignored; LHU at 0x2 with rdata 0xFFFF_0000 -> 0x0000_FFFF.
